// File: rtl/shift_acc_engine.sv
// rtl/shift_acc_engine.sv - shift-and-accumulate engine: acc = (acc << SHIFT) + x over n_iter samples
module shift_acc_engine #(
  parameter int DATA_W = 100,
  parameter int CNT_W  = 7,
  parameter int SHIFT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_iter,
  input  logic              mode,
  input  logic [DATA_W-1:0] x,
  input  logic              x_valid,
  output logic              x_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] y,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int FULL_W = DATA_W + SHIFT + 1;

  state_t              state;
  logic [DATA_W-1:0]   acc;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    n_lat;
  logic                mode_lat;
  logic                sticky;

  logic [FULL_W-1:0]   full;
  logic [DATA_W-1:0]   acc_next;
  logic                step_ovf;
  logic                accept;
  logic                last;

  // Extra headroom bits catch both shifted-out ones and the carry of the add.
  always_comb begin
    full     = (FULL_W'(acc) << SHIFT) + FULL_W'(x);
    step_ovf = |full[FULL_W-1:DATA_W];
    acc_next = (step_ovf && mode_lat) ? '1 : full[DATA_W-1:0];
  end

  assign accept = x_valid && x_ready;
  // Compare against n_lat-1 so the counter never has to reach 2^CNT_W.
  assign last   = accept && (cnt == n_lat - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      n_lat    <= '0;
      mode_lat <= 1'b0;
      sticky   <= 1'b0;
      y        <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      x_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_lat <= mode;
            n_lat    <= n_iter;
            acc      <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
            busy     <= 1'b1;
            if (n_iter != '0) begin
              state   <= RUN;
              x_ready <= 1'b1;
            end else begin
              state <= DONE;
              y     <= '0;
              ovf   <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc    <= acc_next;
            cnt    <= cnt + CNT_W'(1);
            sticky <= sticky | step_ovf;
            if (last) begin
              state   <= DONE;
              x_ready <= 1'b0;
              done    <= 1'b1;
              y       <= acc_next;
              ovf     <= sticky | step_ovf;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          x_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_acc_engine.md
SHIFT_ACC_ENGINE -- requirements
Module: shift_acc_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 100: accumulator, sample and result width in bits.
REQ-002 SHALL have parameter CNT_W, default 7: width of the iteration count and of the internal sample counter.
REQ-003 SHALL have parameter SHIFT, default 1: left-shift applied to the accumulator per step (scale factor 2^SHIFT).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1: begin a run; sampled only in IDLE.
REQ-007 SHALL have port n_iter  input  CNT_W: number of samples in the run; sampled with start.
REQ-008 SHALL have port mode  input  1: 0 = wrap modulo 2^DATA_W, 1 = saturate to all-ones; sampled with start.
REQ-009 SHALL have port x  input  DATA_W: unsigned sample.
REQ-010 SHALL have port x_valid  input  1: x carries a sample this cycle.
REQ-011 SHALL have port x_ready  output  1: engine accepts x this cycle.
REQ-012 SHALL have port busy  output  1: run in progress.
REQ-013 SHALL have port done  output  1: one-cycle pulse marking a valid result on y.
REQ-014 SHALL have port y  output  DATA_W: result of the last completed run.
REQ-015 SHALL have port ovf  output  1: overflow occurred in the last completed run.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 IDLE: start=1 with n_iter>0 SHALL clear acc and counter, latch n_iter and mode, and enter RUN next cycle.
REQ-018 IDLE: start=1 with n_iter=0 SHALL enter DONE with result 0 and ovf 0.
REQ-019 SHALL ignore start in RUN and DONE; the latched n_iter and mode SHALL remain unchanged there.
REQ-020 x_ready SHALL be 1 only in RUN; a sample is accepted when x_valid and x_ready are both 1.
REQ-021 Each accepted sample SHALL update acc to (acc << SHIFT) + x, computed at full precision and then reduced to DATA_W bits.
REQ-022 Overflow SHALL be flagged when any nonzero bit is shifted out of DATA_W or the addition carries out.
REQ-023 mode=0: overflow SHALL wrap modulo 2^DATA_W; mode=1: acc SHALL clamp to 2^DATA_W-1.
REQ-024 Any overflow within a run SHALL set an internal sticky flag, cleared only at the next run start.
REQ-025 Cycles in RUN with x_valid=0 SHALL leave acc and counter unchanged (stall, no timeout).
REQ-026 RUN SHALL transition to DONE in the cycle after the n_iter-th accepted sample.
REQ-027 In DONE, y SHALL equal the final acc and ovf the sticky flag; done SHALL be 1 for exactly that cycle; next state SHALL be IDLE.
REQ-028 y and ovf SHALL hold their values until the next DONE; they SHALL NOT show intermediate accumulation.
REQ-029 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-030 The counter SHALL not wrap: n_iter = 2^CNT_W-1 SHALL accept exactly that many samples.
REQ-031 Throughput SHALL be one sample per cycle; minimum run is n_iter+2 cycles from start to next accepted start.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE and clear acc, counter, sticky flag, y, ovf, done, busy and x_ready to 0.
REQ-033 rst SHALL take priority over start, x_valid and all state transitions; a run in progress SHALL be abandoned with no done pulse.

Verification (DATA_W=8, CNT_W=4, SHIFT=1)
REQ-034 SHALL cover: mode=0, n_iter=3, x=1,2,3 back-to-back -> done 1 cycle after third sample, y=11, ovf=0.
REQ-035 SHALL cover: mode=1, n_iter=2, x=200,200 -> y=255, ovf=1; the same with mode=0 -> y=88, ovf=1.
REQ-036 SHALL cover: n_iter=3 with x_valid gaps of 2 cycles between samples -> y unchanged vs. gapless run, x_ready=1 throughout RUN.
REQ-037 SHALL cover: start with n_iter=0 -> done next cycle, y=0, ovf=0, no sample accepted.
REQ-038 SHALL cover: rst asserted after 2 of 5 samples -> next cycle busy=0, y=0, no done; then a new run of n_iter=1, x=7 -> y=7.
REQ-039 SHALL cover: start pulsed during RUN with different n_iter -> ignored; run completes with the original count.
